shot_pool_controller: RTL
=========================

SHOT_POOL_CONTROLLER -- requirements
Module: shot_pool_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 60000, clk cycles per movement tick.
REQ-002 SHALL have parameter SPAWN_Y, default 424, signed start row for new shots.
REQ-003 SHALL have parameter KILL_Y, default -10, signed row below which a shot dies.
REQ-004 SHALL have parameter AMMO_MAX, default 8, ammo reload value (SHOT_AMMO_EN only).
REQ-005 SHALL have ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- fire_req  in  1  spawn request, held until fire_ack
- pos_x  in  10  launcher x, sampled at spawn
- fire_ack  out  1  one-cycle pulse, request consumed
- fire_drop  out  1  one-cycle pulse with fire_ack when spawn refused
- slot_addr  out  3  slot storage address
- slot_we  out  1  slot storage write strobe
- slot_y_wr  out  10 signed  y write data
- slot_x_wr  out  10  x write data
- slot_y_rd  in  10 signed  y read data, 1-cycle latency after slot_addr
- valid_mask  out  8  per-slot live bits
- active_count  out  4  popcount(valid_mask)
- busy  out  1  high outside IDLE
- reload  in  1  ammo refill pulse (SHOT_AMMO_EN only)
- ammo  out  4  remaining ammo (SHOT_AMMO_EN only)

Function
REQ-006 SHALL count 0..TICK_DIV-1 every cycle, set tick_pend at TICK_DIV-1, wrap to 0; a tick arriving while tick_pend is set is merged.
REQ-007 SHALL implement FSM states IDLE, SPAWN, SCAN_RD, SCAN_WR.
REQ-008 IDLE: fire_req high -> SPAWN (priority over tick); else tick_pend -> SCAN_RD with scan index 0 and tick_pend cleared; else stay.
REQ-009 SPAWN (1 cycle): if a free slot exists, select lowest-index free slot; drive slot_we=1, slot_addr=index, slot_y_wr=SPAWN_Y, slot_x_wr=pos_x; set its valid bit; pulse fire_ack; -> IDLE.
REQ-010 SPAWN with all 8 slots valid: no write, pulse fire_ack and fire_drop; -> IDLE.
REQ-011 SCAN_RD: drive slot_addr=index, slot_we=0; -> SCAN_WR.
REQ-012 SCAN_WR for valid slot: slot_y_rd >= KILL_Y (signed compare) -> write slot_y_rd-1 to same index; else clear valid bit, no write.
REQ-013 SCAN_WR for invalid slot: no write, valid unchanged.
REQ-014 SCAN_WR: index 7 -> IDLE; else index+1 -> SCAN_RD; full scan is 16 cycles.
REQ-015 fire_req asserted during scan SHALL wait; ack issued only after scan completes (latency <= 18 cycles).
REQ-016 slot_we SHALL be 0 in all states except as stated in REQ-009/REQ-012.
REQ-017 active_count and valid_mask SHALL reflect the register state of the same cycle.

Reset
REQ-018 reset SHALL force: state IDLE, valid_mask 0, tick counter 0, tick_pend 0, scan index 0, fire_ack/fire_drop/slot_we/busy 0, slot_addr 0, ammo AMMO_MAX; reset mid-scan abandons the scan.

Configuration
REQ-019 Macro SHOT_AMMO_EN defined: ammo decrements on each successful spawn; spawn with ammo=0 behaves as REQ-010; reload pulse sets ammo=AMMO_MAX (reload wins over same-cycle decrement); ports reload and ammo present.
REQ-020 SHOT_AMMO_EN undefined: ports reload and ammo absent, spawn limited only by free slots.

Structure
REQ-021 Package shot_pkg SHALL hold NSLOTS=8, slot index width, SPAWN_Y/KILL_Y defaults and the FSM state enum.
REQ-022 Tick divider SHALL be sub-module shot_tick_div (TICK_DIV parameter, tick output).

Verification
REQ-023 Reset then fire_req 1 cycle-held with pos_x=100 -> slot_we at addr 0, y=424, x=100, fire_ack, valid_mask=8'h01.
REQ-024 Nine spawns in IDLE -> slots 0..7 filled, ninth gives fire_ack+fire_drop, valid_mask=8'hFF, active_count=8.
REQ-025 TICK_DIV=4, one shot at y=424 -> each scan writes y-1; slot 0 at y=-11 after scan -> valid cleared, no write.
REQ-026 fire_req raised in SCAN_RD index 2 -> no ack until scan ends, then spawn into lowest free slot.
REQ-027 reset asserted in SCAN_WR index 5 -> next cycle IDLE, valid_mask=0, busy=0.
REQ-028 SHOT_AMMO_EN, AMMO_MAX=2: three spawns -> third dropped, ammo=0; reload -> ammo=2.

Source files
------------

// File: rtl/shot_pkg.sv
// Shared constants, FSM state type and small slot-mask helpers for the shot pool.
package shot_pkg;
  localparam int NSLOTS      = 8;
  localparam int IDX_W       = $clog2(NSLOTS);
  localparam int CNT_W       = $clog2(NSLOTS + 1);
  localparam int SPAWN_Y_DEF = 424;
  localparam int KILL_Y_DEF  = -10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPAWN,
    S_SCAN_RD,
    S_SCAN_WR
  } state_t;

  function automatic logic [IDX_W-1:0] lowest_free(input logic [NSLOTS-1:0] m);
    lowest_free = '0;
    for (int i = NSLOTS - 1; i >= 0; i--)
      if (!m[i]) lowest_free = IDX_W'(i);
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NSLOTS-1:0] m);
    popcount = '0;
    for (int i = 0; i < NSLOTS; i++)
      popcount = popcount + CNT_W'(m[i]);
  endfunction
endpackage

// File: rtl/shot_tick_div.sv
// Free-running movement tick divider: one-cycle tick every TICK_DIV clocks.
module shot_tick_div #(
  parameter int TICK_DIV = 60000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/shot_pool_controller.sv
// Shot pool: spawns shots into 8 external slots and moves them one row per tick.
// Optional ammo limit and reload port are enabled by defining SHOT_AMMO_EN.
module shot_pool_controller
  import shot_pkg::*;
#(
  parameter int TICK_DIV = 60000,
  parameter int SPAWN_Y  = SPAWN_Y_DEF,
  parameter int KILL_Y   = KILL_Y_DEF,
  parameter int AMMO_MAX = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fire_req,
  input  logic [9:0]              pos_x,
  output logic                    fire_ack,
  output logic                    fire_drop,
  output logic [IDX_W-1:0]        slot_addr,
  output logic                    slot_we,
  output logic signed [9:0]       slot_y_wr,
  output logic [9:0]              slot_x_wr,
  input  logic signed [9:0]       slot_y_rd,
  output logic [NSLOTS-1:0]       valid_mask,
  output logic [CNT_W-1:0]        active_count,
  output logic                    busy
`ifdef SHOT_AMMO_EN
  ,
  input  logic                    reload,
  output logic [3:0]              ammo
`endif
);
  localparam logic signed [9:0] SPAWN_Y10 = 10'(SPAWN_Y);
  localparam logic signed [9:0] KILL_Y10  = 10'(KILL_Y);

  if (AMMO_MAX < 1 || AMMO_MAX > 15) begin : g_ammo_range
    $error("AMMO_MAX must fit the 4-bit ammo counter");
  end

  state_t           state, state_nx;
  logic [IDX_W-1:0] scan_idx;
  logic             tick, tick_pend;
  logic             spawn_ok, keep_y, start_scan;
  logic [IDX_W-1:0] free_idx;

  shot_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign free_idx     = lowest_free(valid_mask);
  assign keep_y       = (slot_y_rd >= KILL_Y10);
  assign start_scan   = (state == S_IDLE) && !fire_req && tick_pend;
  assign active_count = popcount(valid_mask);

`ifdef SHOT_AMMO_EN
  assign spawn_ok = !(&valid_mask) && (ammo != 4'd0);
`else
  assign spawn_ok = !(&valid_mask);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (fire_req)       state_nx = S_SPAWN;
                 else if (tick_pend) state_nx = S_SCAN_RD;
      S_SPAWN:   state_nx = S_IDLE;
      S_SCAN_RD: state_nx = S_SCAN_WR;
      S_SCAN_WR: state_nx = (scan_idx == IDX_W'(NSLOTS - 1)) ? S_IDLE : S_SCAN_RD;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    fire_ack  = 1'b0;
    fire_drop = 1'b0;
    slot_we   = 1'b0;
    slot_addr = '0;
    slot_y_wr = '0;
    slot_x_wr = '0;
    busy      = (state != S_IDLE);
    case (state)
      S_SPAWN: begin
        fire_ack  = 1'b1;
        fire_drop = !spawn_ok;
        slot_we   = spawn_ok;
        slot_addr = spawn_ok ? free_idx : '0;
        slot_y_wr = SPAWN_Y10;
        slot_x_wr = pos_x;
      end
      S_SCAN_RD: slot_addr = scan_idx;
      S_SCAN_WR: begin
        slot_addr = scan_idx;
        slot_we   = valid_mask[scan_idx] && keep_y;
        slot_y_wr = slot_y_rd - 10'sd1;
      end
      default: ;
    endcase
  end

  // A tick landing on the same cycle the pending flag is consumed starts a fresh pending tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_pend  <= 1'b0;
      scan_idx   <= '0;
      valid_mask <= '0;
    end else begin
      if (tick)            tick_pend <= 1'b1;
      else if (start_scan) tick_pend <= 1'b0;

      if (start_scan)                scan_idx <= '0;
      else if (state == S_SCAN_WR)   scan_idx <= scan_idx + 1'b1;

      if (state == S_SPAWN && spawn_ok)
        valid_mask[free_idx] <= 1'b1;
      else if (state == S_SCAN_WR && valid_mask[scan_idx] && !keep_y)
        valid_mask[scan_idx] <= 1'b0;
    end
  end

`ifdef SHOT_AMMO_EN
  always_ff @(posedge clk) begin
    if (reset || reload)                   ammo <= 4'(AMMO_MAX);
    else if (state == S_SPAWN && spawn_ok) ammo <= ammo - 4'd1;
  end
`endif
endmodule
